mc_cu: RTL and testbench

MC_CU -- requirements
Module: mc_cu

---
 rtl/mc_cu.sv | 175 +++++++++++++++++
 tb/tb_mc_cu.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_cu.sv
// Multicycle MIPS control unit: IF/ID/EXE/MEM/WB FSM with combinational strobe decode.
// Optional MC_CU_SLT_EN adds slt/sltu/slti; all outputs are decodes of state and inputs.
module mc_cu #(
    parameter int MEM_HS = 1,
    parameter int ALUC_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [5:0]        op,
    input  logic [5:0]        func,
    input  logic              z,
    input  logic              mem_ready,
    output logic              wpc,
    output logic              wir,
    output logic              wmem,
    output logic              wreg,
    output logic              iord,
    output logic              m2reg,
    output logic              regrt,
    output logic              shift,
    output logic              alusrca,
    output logic              jal,
    output logic              sext,
    output logic              mem_req,
    output logic              illegal,
    output logic [1:0]        alusrcb,
    output logic [1:0]        pcsource,
    output logic [ALUC_W-1:0] aluc,
    output logic [2:0]        state
);

    generate
        if (ALUC_W < 4) begin : g_aluc_w_chk
            $error("mc_cu: ALUC_W must be at least 4");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IF  = 3'b000,
        S_ID  = 3'b001,
        S_EXE = 3'b010,
        S_MEM = 3'b011,
        S_WB  = 3'b100
    } state_t;

    localparam logic [3:0] A_ADD = 4'b0000, A_SUB = 4'b0100, A_AND = 4'b0001,
                           A_OR  = 4'b0101, A_XOR = 4'b0010, A_LUI = 4'b0110,
                           A_SLL = 4'b0011, A_SRL = 4'b0111, A_SRA = 4'b1111;

    state_t     state_q, state_d;
    logic       legal, imm_form, itype_wr, sext_c, shift_c;
    logic       is_j, is_jal, is_jr, is_beq, is_bne, is_lw, is_sw;
    logic [3:0] alu_op, aluc4;
    logic       mem_done;

    assign mem_done = (MEM_HS == 0) || mem_ready;

    // Instruction decode, independent of FSM state.
    always_comb begin
        legal = 1'b0; imm_form = 1'b0; itype_wr = 1'b0; sext_c = 1'b0; shift_c = 1'b0;
        is_j = 1'b0; is_jal = 1'b0; is_jr = 1'b0; is_beq = 1'b0; is_bne = 1'b0;
        is_lw = 1'b0; is_sw = 1'b0; alu_op = A_ADD;
        if (op == 6'b000000) begin
            case (func)
                6'b100000: begin legal = 1'b1; alu_op = A_ADD; end
                6'b100010: begin legal = 1'b1; alu_op = A_SUB; end
                6'b100100: begin legal = 1'b1; alu_op = A_AND; end
                6'b100101: begin legal = 1'b1; alu_op = A_OR;  end
                6'b100110: begin legal = 1'b1; alu_op = A_XOR; end
                6'b000000: begin legal = 1'b1; alu_op = A_SLL; shift_c = 1'b1; end
                6'b000010: begin legal = 1'b1; alu_op = A_SRL; shift_c = 1'b1; end
                6'b000011: begin legal = 1'b1; alu_op = A_SRA; shift_c = 1'b1; end
                6'b001000: begin legal = 1'b1; is_jr = 1'b1; end
`ifdef MC_CU_SLT_EN
                6'b101010: begin legal = 1'b1; alu_op = 4'b1000; end
                6'b101011: begin legal = 1'b1; alu_op = 4'b1001; end
`endif
                default: ;
            endcase
        end else begin
            case (op)
                6'b001000: begin legal = 1'b1; imm_form = 1'b1; itype_wr = 1'b1; sext_c = 1'b1; end
                6'b001100: begin legal = 1'b1; imm_form = 1'b1; itype_wr = 1'b1; alu_op = A_AND; end
                6'b001101: begin legal = 1'b1; imm_form = 1'b1; itype_wr = 1'b1; alu_op = A_OR;  end
                6'b001110: begin legal = 1'b1; imm_form = 1'b1; itype_wr = 1'b1; alu_op = A_XOR; end
                6'b001111: begin legal = 1'b1; imm_form = 1'b1; itype_wr = 1'b1; alu_op = A_LUI; end
                6'b100011: begin legal = 1'b1; imm_form = 1'b1; itype_wr = 1'b1; sext_c = 1'b1; is_lw = 1'b1; end
                6'b101011: begin legal = 1'b1; imm_form = 1'b1; sext_c = 1'b1; is_sw = 1'b1; end
                6'b000100: begin legal = 1'b1; sext_c = 1'b1; is_beq = 1'b1; alu_op = A_SUB; end
                6'b000101: begin legal = 1'b1; sext_c = 1'b1; is_bne = 1'b1; alu_op = A_SUB; end
                6'b000010: begin legal = 1'b1; is_j = 1'b1; end
                6'b000011: begin legal = 1'b1; is_jal = 1'b1; end
`ifdef MC_CU_SLT_EN
                6'b001010: begin legal = 1'b1; imm_form = 1'b1; itype_wr = 1'b1; sext_c = 1'b1; alu_op = 4'b1000; end
`endif
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        wpc = 1'b0; wir = 1'b0; wmem = 1'b0; wreg = 1'b0; iord = 1'b0; m2reg = 1'b0;
        regrt = 1'b0; alusrca = 1'b0; jal = 1'b0; mem_req = 1'b0; illegal = 1'b0;
        alusrcb = 2'b00; pcsource = 2'b00; aluc4 = A_ADD;
        case (state_q)
            S_IF: begin
                mem_req = 1'b1;
                alusrcb = 2'b01;
                if (mem_done) begin
                    wir = 1'b1; wpc = 1'b1; state_d = S_ID;
                end
            end
            S_ID: begin
                alusrcb = 2'b11;
                state_d = S_IF;
                if (!legal) begin
                    illegal = 1'b1;
                end else if (is_j || is_jal) begin
                    wpc = 1'b1; pcsource = 2'b11; jal = is_jal; wreg = is_jal;
                end else if (is_jr) begin
                    wpc = 1'b1; pcsource = 2'b10;
                end else begin
                    state_d = S_EXE;
                end
            end
            S_EXE: begin
                alusrca = shift_c;
                alusrcb = imm_form ? 2'b10 : 2'b00;
                aluc4   = alu_op;
                if (is_beq || is_bne) begin
                    state_d = S_IF;
                    if ((is_beq && z) || (is_bne && !z)) begin
                        wpc = 1'b1; pcsource = 2'b01;
                    end
                end else if (is_lw || is_sw) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_done) begin
                    wmem    = is_sw;
                    state_d = is_sw ? S_IF : S_WB;
                end
            end
            S_WB: begin
                wreg = 1'b1; m2reg = is_lw; regrt = itype_wr; state_d = S_IF;
            end
            default: state_d = S_IF;
        endcase
        // Reset is asynchronous, so strobes are masked directly rather than via state.
        if (reset) begin
            wpc = 1'b0; wir = 1'b0; wmem = 1'b0; wreg = 1'b0; mem_req = 1'b0;
        end
    end

    always_comb begin
        aluc      = '0;
        aluc[3:0] = aluc4;
    end

    assign sext  = sext_c;
    assign shift = shift_c;
    assign state = state_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= S_IF;
        else       state_q <= state_d;
    end

endmodule

// File: tb/tb_mc_cu.sv
// Bench for mc_cu: per-instruction expected cycle traces built from the ISA rules,
// replayed against a handshaking and a non-handshaking instance.
module tb_mc_cu;

`ifdef MC_CU_SLT_EN
    localparam bit SLT = 1'b1;
`else
    localparam bit SLT = 1'b0;
`endif

    localparam int K_ALU = 0, K_LW = 1, K_SW = 2, K_BEQ = 3, K_BNE = 4, K_J = 5, K_JAL = 6, K_JR = 7;

    typedef struct packed {
        logic [2:0] st;
        logic wpc, wir, wmem, wreg, mem_req, iord, m2reg, regrt, shift, alusrca, jal, sext, illegal;
        logic [1:0] asb, pcs;
        logic [3:0] aluc;
    } obs_t;

    typedef struct packed {
        logic [5:0] op, fn;
        logic [2:0] kind;
        logic [3:0] aluc;
        logic imm, sx, sh, rt, legal;
    } ins_t;

    typedef struct {
        obs_t e, m;
        logic rdy, hs, z;
        logic [5:0] op, fn;
    } ent_t;

    logic clock = 1'b0, reset = 1'b1, z = 1'b0, mem_ready = 1'b1;
    logic [5:0] op = 6'd0, func = 6'd0;

    logic p1_wpc, p1_wir, p1_wmem, p1_wreg, p1_iord, p1_m2reg, p1_regrt, p1_shift;
    logic p1_alusrca, p1_jal, p1_sext, p1_mem_req, p1_illegal;
    logic [1:0] p1_alusrcb, p1_pcsource;
    logic [3:0] p1_aluc;
    logic [2:0] p1_state;
    logic p0_wpc, p0_wir, p0_wmem, p0_wreg, p0_iord, p0_m2reg, p0_regrt, p0_shift;
    logic p0_alusrca, p0_jal, p0_sext, p0_mem_req, p0_illegal;
    logic [1:0] p0_alusrcb, p0_pcsource;
    logic [3:0] p0_aluc;
    logic [2:0] p0_state;

    mc_cu #(.MEM_HS(1), .ALUC_W(4)) u1 (
        .clock(clock), .reset(reset), .op(op), .func(func), .z(z), .mem_ready(mem_ready),
        .wpc(p1_wpc), .wir(p1_wir), .wmem(p1_wmem), .wreg(p1_wreg), .iord(p1_iord),
        .m2reg(p1_m2reg), .regrt(p1_regrt), .shift(p1_shift), .alusrca(p1_alusrca),
        .jal(p1_jal), .sext(p1_sext), .mem_req(p1_mem_req), .illegal(p1_illegal),
        .alusrcb(p1_alusrcb), .pcsource(p1_pcsource), .aluc(p1_aluc), .state(p1_state));

    mc_cu #(.MEM_HS(0), .ALUC_W(4)) u0 (
        .clock(clock), .reset(reset), .op(op), .func(func), .z(z), .mem_ready(mem_ready),
        .wpc(p0_wpc), .wir(p0_wir), .wmem(p0_wmem), .wreg(p0_wreg), .iord(p0_iord),
        .m2reg(p0_m2reg), .regrt(p0_regrt), .shift(p0_shift), .alusrca(p0_alusrca),
        .jal(p0_jal), .sext(p0_sext), .mem_req(p0_mem_req), .illegal(p0_illegal),
        .alusrcb(p0_alusrcb), .pcsource(p0_pcsource), .aluc(p0_aluc), .state(p0_state));

    obs_t o1, o0;
    assign o1 = {p1_state, p1_wpc, p1_wir, p1_wmem, p1_wreg, p1_mem_req, p1_iord, p1_m2reg,
                 p1_regrt, p1_shift, p1_alusrca, p1_jal, p1_sext, p1_illegal,
                 p1_alusrcb, p1_pcsource, p1_aluc};
    assign o0 = {p0_state, p0_wpc, p0_wir, p0_wmem, p0_wreg, p0_mem_req, p0_iord, p0_m2reg,
                 p0_regrt, p0_shift, p0_alusrca, p0_jal, p0_sext, p0_illegal,
                 p0_alusrcb, p0_pcsource, p0_aluc};

    always #5 clock = ~clock;

    int checks = 0, errors = 0;
    ins_t tbl[25];
    ent_t q[$];

    function automatic ins_t mk(logic [5:0] o, logic [5:0] f, int k, logic [3:0] a,
                                bit imm, bit sx, bit sh, bit rt, bit lg);
        ins_t t;
        t.op = o; t.fn = f; t.kind = 3'(k); t.aluc = a;
        t.imm = imm; t.sx = sx; t.sh = sh; t.rt = rt; t.legal = lg;
        return t;
    endfunction

    task automatic chk(input string tag, input obs_t o, input obs_t x, input obs_t msk);
        checks++;
        assert ((o & msk) === (x & msk)) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h mask=%h", tag, o, x, msk);
        end
    endtask

    // Fields always defined: state, write strobes, mem_req, illegal, jal.
    task automatic base(input logic [2:0] st, output obs_t e, output obs_t m);
        e = '0; m = '0;
        e.st = st; m.st = '1;
        m.wpc = 1; m.wir = 1; m.wmem = 1; m.wreg = 1; m.mem_req = 1; m.illegal = 1; m.jal = 1;
    endtask

    task automatic push(input obs_t e, input obs_t m, input logic rdy, input bit hs,
                        input logic [5:0] o, input logic [5:0] f, input logic zv);
        ent_t n;
        n.e = e; n.m = m; n.rdy = rdy; n.hs = hs; n.op = o; n.fn = f; n.z = zv;
        q.push_back(n);
    endtask

    // Expected cycle-by-cycle trace of one instruction; stall counts of -1 mean random.
    task automatic gen(input int idx, input bit hs, input bit zv, input int if_st, input int mem_st);
        ins_t t;
        obs_t e, m;
        logic [5:0] fn;
        int ns;
        bit done, br, taken;
        t  = tbl[idx];
        fn = (t.op == 6'd0) ? t.fn : 6'($urandom);
        ns = !hs ? 0 : (if_st >= 0) ? if_st : int'($urandom_range(0, 2));
        for (int s = 0; s <= ns; s++) begin
            done = (s == ns);
            base(3'd0, e, m);
            e.mem_req = 1; m.iord = 1; m.alusrca = 1;
            e.asb = 2'b01; m.asb = '1; m.pcs = '1; m.aluc = '1;
            e.wpc = done; e.wir = done;
            push(e, m, hs ? done : 1'($urandom), hs, t.op, fn, zv);
        end
        base(3'd1, e, m);
        e.asb = 2'b11; m.asb = '1; m.aluc = '1;
        if (!t.legal) e.illegal = 1;
        else if (t.kind == K_J || t.kind == K_JAL) begin
            e.wpc = 1; e.pcs = 2'b11; m.pcs = '1;
            e.jal = (t.kind == K_JAL); e.wreg = (t.kind == K_JAL);
        end else if (t.kind == K_JR) begin
            e.wpc = 1; e.pcs = 2'b10; m.pcs = '1;
        end
        push(e, m, 1'($urandom), hs, t.op, fn, zv);
        if (!t.legal || t.kind == K_J || t.kind == K_JAL || t.kind == K_JR) return;
        base(3'd2, e, m);
        e.alusrca = t.sh; e.shift = t.sh; e.sext = t.sx; e.aluc = t.aluc;
        e.asb = t.imm ? 2'b10 : 2'b00;
        m.alusrca = 1; m.shift = 1; m.sext = 1; m.aluc = '1; m.asb = '1;
        br    = (t.kind == K_BEQ || t.kind == K_BNE);
        taken = (t.kind == K_BEQ && zv) || (t.kind == K_BNE && !zv);
        if (taken) begin e.wpc = 1; e.pcs = 2'b01; m.pcs = '1; end
        push(e, m, 1'($urandom), hs, t.op, fn, zv);
        if (br) return;
        if (t.kind == K_LW || t.kind == K_SW) begin
            ns = !hs ? 0 : (mem_st >= 0) ? mem_st : int'($urandom_range(0, 2));
            for (int s = 0; s <= ns; s++) begin
                done = (s == ns);
                base(3'd3, e, m);
                e.mem_req = 1; e.iord = 1; m.iord = 1;
                e.wmem = done && (t.kind == K_SW);
                push(e, m, hs ? done : 1'($urandom), hs, t.op, fn, zv);
            end
            if (t.kind == K_SW) return;
        end
        base(3'd4, e, m);
        e.wreg = 1; e.m2reg = (t.kind == K_LW); e.regrt = t.rt;
        m.m2reg = 1; m.regrt = 1;
        push(e, m, 1'($urandom), hs, t.op, fn, zv);
    endtask

    // Entered one time unit after a rising edge; leaves at the same point.
    task automatic run(input int n);
        ent_t c;
        for (int k = 0; k < n && q.size() > 0; k++) begin
            c = q.pop_front();
            op = c.op; func = c.fn; z = c.z; mem_ready = c.rdy;
            @(negedge clock);
            chk($sformatf("trace_hs%0d_op%b", c.hs, c.op), c.hs ? o1 : o0, c.e, c.m);
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_reset();
        obs_t e, m;
        reset = 1'b1; mem_ready = 1'b1;
        #2;
        base(3'd0, e, m);
        chk("reset_hs1", o1, e, m);
        chk("reset_hs0", o0, e, m);
        @(posedge clock);
        #1;
        reset = 1'b0; mem_ready = 1'b0;
    endtask

    initial begin
        obs_t e, m;
        tbl[0]  = mk(6'o00, 6'b100000, K_ALU, 4'b0000, 0, 0, 0, 0, 1);
        tbl[1]  = mk(6'o00, 6'b100010, K_ALU, 4'b0100, 0, 0, 0, 0, 1);
        tbl[2]  = mk(6'o00, 6'b100100, K_ALU, 4'b0001, 0, 0, 0, 0, 1);
        tbl[3]  = mk(6'o00, 6'b100101, K_ALU, 4'b0101, 0, 0, 0, 0, 1);
        tbl[4]  = mk(6'o00, 6'b100110, K_ALU, 4'b0010, 0, 0, 0, 0, 1);
        tbl[5]  = mk(6'o00, 6'b000000, K_ALU, 4'b0011, 0, 0, 1, 0, 1);
        tbl[6]  = mk(6'o00, 6'b000010, K_ALU, 4'b0111, 0, 0, 1, 0, 1);
        tbl[7]  = mk(6'o00, 6'b000011, K_ALU, 4'b1111, 0, 0, 1, 0, 1);
        tbl[8]  = mk(6'o00, 6'b001000, K_JR,  4'b0000, 0, 0, 0, 0, 1);
        tbl[9]  = mk(6'b001000, 6'd0, K_ALU, 4'b0000, 1, 1, 0, 1, 1);
        tbl[10] = mk(6'b001100, 6'd0, K_ALU, 4'b0001, 1, 0, 0, 1, 1);
        tbl[11] = mk(6'b001101, 6'd0, K_ALU, 4'b0101, 1, 0, 0, 1, 1);
        tbl[12] = mk(6'b001110, 6'd0, K_ALU, 4'b0010, 1, 0, 0, 1, 1);
        tbl[13] = mk(6'b001111, 6'd0, K_ALU, 4'b0110, 1, 0, 0, 1, 1);
        tbl[14] = mk(6'b100011, 6'd0, K_LW,  4'b0000, 1, 1, 0, 1, 1);
        tbl[15] = mk(6'b101011, 6'd0, K_SW,  4'b0000, 1, 1, 0, 0, 1);
        tbl[16] = mk(6'b000100, 6'd0, K_BEQ, 4'b0100, 0, 1, 0, 0, 1);
        tbl[17] = mk(6'b000101, 6'd0, K_BNE, 4'b0100, 0, 1, 0, 0, 1);
        tbl[18] = mk(6'b000010, 6'd0, K_J,   4'b0000, 0, 0, 0, 0, 1);
        tbl[19] = mk(6'b000011, 6'd0, K_JAL, 4'b0000, 0, 0, 0, 0, 1);
        tbl[20] = mk(6'b111111, 6'd0, K_ALU, 4'b0000, 0, 0, 0, 0, 0);
        tbl[21] = mk(6'o00, 6'b101010, K_ALU, 4'b1000, 0, 0, 0, 0, SLT);
        tbl[22] = mk(6'o00, 6'b101011, K_ALU, 4'b1001, 0, 0, 0, 0, SLT);
        tbl[23] = mk(6'b001010, 6'd0, K_ALU, 4'b1000, 1, 1, 0, 1, SLT);
        tbl[24] = mk(6'o00, 6'b000001, K_ALU, 4'b0000, 0, 0, 0, 0, 0);

        #12;
        base(3'd0, e, m);
        chk("reset_initial_hs1", o1, e, m);
        chk("reset_initial_hs0", o0, e, m);
        @(posedge clock);
        #1;
        reset = 1'b0; mem_ready = 1'b0;

        // Single-cycle memory instance: directed then random.
        gen(0, 0, 0, 0, 0);  gen(15, 0, 0, 0, 0); gen(14, 0, 0, 0, 0);
        gen(18, 0, 0, 0, 0); gen(8, 0, 0, 0, 0);  gen(16, 0, 1, 0, 0);
        run(q.size());
        for (int i = 0; i < 40; i++) gen($urandom_range(0, 24), 0, 1'($urandom), 0, 0);
        run(q.size());
        do_reset();

        // Reset while lw is stalled in MEM.
        gen(14, 1, 0, 0, 3);
        run(4);
        base(3'd3, e, m);
        e.mem_req = 1; e.iord = 1; m.iord = 1;
        chk("mem_wait_before_reset", o1, e, m);
        reset = 1'b1;
        #1;
        base(3'd0, e, m);
        chk("mem_wait_reset", o1, e, m);
        q.delete();
        @(posedge clock);
        #1;
        reset = 1'b0; mem_ready = 1'b0;
        gen(0, 1, 0, 1, 0);
        run(q.size());

        // Handshaking instance: directed then random.
        gen(14, 1, 0, 0, 2); gen(16, 1, 1, 0, 0); gen(16, 1, 0, 0, 0);
        gen(17, 1, 1, 0, 0); gen(17, 1, 0, 0, 0); gen(19, 1, 0, 0, 0);
        gen(20, 1, 0, 0, 0); gen(21, 1, 0, 0, 0); gen(22, 1, 0, 0, 0);
        gen(23, 1, 0, 0, 0); gen(15, 1, 0, 2, 1); gen(7, 1, 0, 0, 0);
        run(q.size());
        for (int i = 0; i < 60; i++) gen($urandom_range(0, 24), 1, 1'($urandom), -1, -1);
        run(q.size());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
